// File: rtl/tag_compare_wb.sv
// Tag comparator for the DRAM cache: classifies one tag+data beat per request as read/write hit/miss
// and issues the resulting ROB / AR / AW+W / fill transfers, with dirty-victim writeback and stats.
module tag_compare_wb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 512,
  parameter int TID_WIDTH    = 4,
  parameter int INDEX_WIDTH  = 20,
  parameter int OFFSET_WIDTH = 6,
  parameter int TAG_SIZE     = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [TAG_SIZE+DATA_WIDTH-1:0]   rdata_i,
  input  logic                             rvalid_i,
  output logic                             rready_o,
  input  logic                             tag_fifo_empty_i,
  output logic                             tag_fifo_rden_o,
  input  logic [TID_WIDTH+ADDR_WIDTH:0]    tag_fifo_data_i,
  input  logic                             wbuffer_empty_i,
  output logic                             wbuffer_rden_o,
  input  logic [DATA_WIDTH-1:0]            wbuffer_data_i,
  input  logic                             rob_afull_i,
  output logic                             rob_wren_o,
  output logic [TID_WIDTH+DATA_WIDTH-1:0]  rob_data_o,
  input  logic                             ar_fifo_afull_i,
  output logic                             ar_fifo_wren_o,
  output logic [TID_WIDTH+ADDR_WIDTH-1:0]  ar_fifo_data_o,
  input  logic                             aw_fifo_afull_i,
  output logic                             aw_fifo_wren_o,
  output logic [ADDR_WIDTH-1:0]            aw_fifo_data_o,
  input  logic                             w_fifo_afull_i,
  output logic                             w_fifo_wren_o,
  output logic [DATA_WIDTH-1:0]            w_fifo_data_o,
  input  logic                             fill_ready_i,
  output logic                             fill_valid_o,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_o,
  input  logic                             stat_clr_i,
  output logic [CNT_WIDTH-1:0]             hit_cnt_o,
  output logic [CNT_WIDTH-1:0]             miss_cnt_o,
  output logic [CNT_WIDTH-1:0]             wb_cnt_o
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int RD_WIDTH  = TAG_SIZE + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEC   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    is_write_q;
  logic [TID_WIDTH-1:0]    tid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    line_v_q;
  logic                    line_d_q;
  logic [TAG_WIDTH-1:0]    line_tag_q;
  logic [DATA_WIDTH-1:0]   line_q;
  logic [DATA_WIDTH-1:0]   wline_q;
  logic                    pend_rob_q, pend_ar_q, pend_wb_q, pend_fill_q;
  logic [TID_WIDTH+DATA_WIDTH-1:0]  rob_data_q;
  logic [TID_WIDTH+ADDR_WIDTH-1:0]  ar_data_q;
  logic [ADDR_WIDTH-1:0]            aw_data_q;
  logic [DATA_WIDTH-1:0]            w_data_q;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_q;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic                    req_is_write;
  logic [TID_WIDTH-1:0]    req_tid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    go;
  logic                    hit;
  logic                    victim_wb;
  logic [ADDR_WIDTH-1:0]   victim_addr;
  logic                    in_issue;
  logic                    rob_fire, ar_fire, wb_fire, fill_fire;
  logic                    issue_done;
  logic                    unused_tag_word;

  assign req_is_write = tag_fifo_data_i[TID_WIDTH+ADDR_WIDTH];
  assign req_tid      = tag_fifo_data_i[ADDR_WIDTH +: TID_WIDTH];
  assign req_addr     = tag_fifo_data_i[ADDR_WIDTH-1:0];

  // Accept handshake is combinational so the beat and the tag entry are consumed in the same cycle.
  assign go = rst_n && (state_q == S_IDLE) && rvalid_i && !tag_fifo_empty_i
              && (!req_is_write || !wbuffer_empty_i);

  assign rready_o        = go;
  assign tag_fifo_rden_o = go;
  assign wbuffer_rden_o  = go && req_is_write;

  assign hit         = line_v_q && (addr_q[ADDR_WIDTH-1 -: TAG_WIDTH] == line_tag_q);
  assign victim_wb   = line_v_q && line_d_q && !hit;
  assign victim_addr = {line_tag_q, addr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH],
                        {OFFSET_WIDTH{1'b0}}};

  // Outputs issue independently; AW and W are gated together so the victim pair never splits.
  assign in_issue   = rst_n && (state_q == S_ISSUE);
  assign rob_fire   = in_issue && pend_rob_q && !rob_afull_i;
  assign ar_fire    = in_issue && pend_ar_q && !ar_fifo_afull_i;
  assign wb_fire    = in_issue && pend_wb_q && !aw_fifo_afull_i && !w_fifo_afull_i;
  assign fill_fire  = fill_valid_o && fill_ready_i;
  assign issue_done = !(pend_rob_q && !rob_fire) && !(pend_ar_q && !ar_fire)
                      && !(pend_wb_q && !wb_fire) && !(pend_fill_q && !fill_fire);

  assign rob_wren_o     = rob_fire;
  assign ar_fifo_wren_o = ar_fire;
  assign aw_fifo_wren_o = wb_fire;
  assign w_fifo_wren_o  = wb_fire;
  assign fill_valid_o   = in_issue && pend_fill_q;

  assign rob_data_o     = rob_fire     ? {tid_q, line_q}   : rob_data_q;
  assign ar_fifo_data_o = ar_fire      ? {tid_q, addr_q}   : ar_data_q;
  assign aw_fifo_data_o = wb_fire      ? victim_addr       : aw_data_q;
  assign w_fifo_data_o  = wb_fire      ? line_q            : w_data_q;
  assign fill_data_o    = fill_valid_o ? {addr_q, wline_q} : fill_data_q;

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;

  // The blank bits between the tag and the line carry nothing for this block.
  assign unused_tag_word = ^rdata_i[RD_WIDTH-1 -: TAG_SIZE];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_rob_q  <= 1'b0;
      pend_ar_q   <= 1'b0;
      pend_wb_q   <= 1'b0;
      pend_fill_q <= 1'b0;
      rob_data_q  <= '0;
      ar_data_q   <= '0;
      aw_data_q   <= '0;
      w_data_q    <= '0;
      fill_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) state_q <= S_DEC;
        end
        S_DEC: begin
          pend_rob_q  <= !is_write_q && hit;
          pend_ar_q   <= !is_write_q && !hit;
          pend_wb_q   <= victim_wb;
          pend_fill_q <= is_write_q;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (rob_fire)  pend_rob_q  <= 1'b0;
          if (ar_fire)   pend_ar_q   <= 1'b0;
          if (wb_fire)   pend_wb_q   <= 1'b0;
          if (fill_fire) pend_fill_q <= 1'b0;
          if (issue_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (rob_fire)  rob_data_q  <= {tid_q, line_q};
      if (ar_fire)   ar_data_q   <= {tid_q, addr_q};
      if (wb_fire)   aw_data_q   <= victim_addr;
      if (wb_fire)   w_data_q    <= line_q;
      if (fill_fire) fill_data_q <= {addr_q, wline_q};
    end
  end

  // NOTE: capture registers are only read after a qualified load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (go) begin
      is_write_q <= req_is_write;
      tid_q      <= req_tid;
      addr_q     <= req_addr;
      line_v_q   <= rdata_i[RD_WIDTH-1];
      line_d_q   <= rdata_i[RD_WIDTH-2];
      line_tag_q <= rdata_i[RD_WIDTH-3 -: TAG_WIDTH];
      line_q     <= rdata_i[DATA_WIDTH-1:0];
      if (req_is_write) wline_q <= wbuffer_data_i;
    end
  end

  // Saturating statistics; a clear in the same cycle as an increment leaves the counter at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == S_DEC && hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + CNT_ONE;
      if (state_q == S_DEC && !hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_ONE;
      if (wb_fire && wb_cnt_q != '1)                    wb_cnt_q   <= wb_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_tag_compare_wb.sv
// Bench for tag_compare_wb: table of hit/miss vectors plus hand sequences for back-pressure,
// clear/saturation and mid-operation reset; a per-channel scoreboard checks every output transfer.
module tb_tag_compare_wb;

  localparam int AW   = 32;
  localparam int DW   = 512;
  localparam int TW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [16+DW-1:0]    rdata_i;
  logic                rvalid_i, rready_o;
  logic                tag_fifo_empty_i, tag_fifo_rden_o;
  logic [TW+AW:0]      tag_fifo_data_i;
  logic                wbuffer_empty_i, wbuffer_rden_o;
  logic [DW-1:0]       wbuffer_data_i;
  logic                rob_afull_i, rob_wren_o;
  logic [TW+DW-1:0]    rob_data_o;
  logic                ar_fifo_afull_i, ar_fifo_wren_o;
  logic [TW+AW-1:0]    ar_fifo_data_o;
  logic                aw_fifo_afull_i, aw_fifo_wren_o;
  logic [AW-1:0]       aw_fifo_data_o;
  logic                w_fifo_afull_i, w_fifo_wren_o;
  logic [DW-1:0]       w_fifo_data_o;
  logic                fill_ready_i, fill_valid_o;
  logic [AW+DW-1:0]    fill_data_o;
  logic                stat_clr_i;
  logic [CW-1:0]       hit_cnt_o, miss_cnt_o, wb_cnt_o;

  tag_compare_wb #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .tag_fifo_empty_i(tag_fifo_empty_i), .tag_fifo_rden_o(tag_fifo_rden_o),
    .tag_fifo_data_i(tag_fifo_data_i),
    .wbuffer_empty_i(wbuffer_empty_i), .wbuffer_rden_o(wbuffer_rden_o),
    .wbuffer_data_i(wbuffer_data_i),
    .rob_afull_i(rob_afull_i), .rob_wren_o(rob_wren_o), .rob_data_o(rob_data_o),
    .ar_fifo_afull_i(ar_fifo_afull_i), .ar_fifo_wren_o(ar_fifo_wren_o),
    .ar_fifo_data_o(ar_fifo_data_o),
    .aw_fifo_afull_i(aw_fifo_afull_i), .aw_fifo_wren_o(aw_fifo_wren_o),
    .aw_fifo_data_o(aw_fifo_data_o),
    .w_fifo_afull_i(w_fifo_afull_i), .w_fifo_wren_o(w_fifo_wren_o),
    .w_fifo_data_o(w_fifo_data_o),
    .fill_ready_i(fill_ready_i), .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o),
    .stat_clr_i(stat_clr_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard queues, one per output channel
  logic [TW+DW-1:0] rob_q[$];
  logic [TW+AW-1:0] ar_q[$];
  logic [AW-1:0]    aw_q[$];
  logic [DW-1:0]    w_q[$];
  logic [AW+DW-1:0] fill_q[$];

  int cyc = 0, acc_cyc = 0, aw_cyc = 0, fill_cyc = 0;
  int n_accept = 0, n_wbrd = 0, n_fv = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;
  logic             prev_fill_wait = 1'b0;
  logic [AW+DW-1:0] prev_fill_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rready_o) begin
        acc_cyc = cyc;
        n_accept++;
      end
      if (wbuffer_rden_o) n_wbrd++;
      if (rready_o || tag_fifo_rden_o) check("rready_rden_pair", rready_o, tag_fifo_rden_o);
      if (rob_wren_o) begin
        if (rob_q.size() == 0) fail_now("rob_unexpected");
        else begin
          check("rob_data", rob_data_o, rob_q.pop_front());
          check("rob_latency", cyc - acc_cyc, 2);
        end
      end
      if (ar_fifo_wren_o) begin
        if (ar_q.size() == 0) fail_now("ar_unexpected");
        else begin
          check("ar_data", ar_fifo_data_o, ar_q.pop_front());
          check("ar_latency", cyc - acc_cyc, 2);
        end
      end
      if (aw_fifo_wren_o || w_fifo_wren_o) begin
        aw_cyc = cyc;
        check("aw_w_together", aw_fifo_wren_o, w_fifo_wren_o);
        check("aw_afull_respected", aw_fifo_afull_i, 0);
        check("w_afull_respected", w_fifo_afull_i, 0);
        if (aw_q.size() == 0 || w_q.size() == 0) fail_now("aw_w_unexpected");
        else begin
          check("aw_data", aw_fifo_data_o, aw_q.pop_front());
          check("w_data", w_fifo_data_o, w_q.pop_front());
        end
      end
      if (fill_valid_o) begin
        n_fv++;
        if (prev_fill_wait) check("fill_data_stable", fill_data_o, prev_fill_data);
        if (fill_ready_i) begin
          fill_cyc = cyc;
          if (fill_q.size() == 0) fail_now("fill_unexpected");
          else check("fill_data", fill_data_o, fill_q.pop_front());
        end
        prev_fill_wait = !fill_ready_i;
        prev_fill_data = fill_data_o;
      end else begin
        prev_fill_wait = 1'b0;
      end
    end else begin
      prev_fill_wait = 1'b0;
    end
  end

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  function automatic logic [DW-1:0] make_line(input int seed);
    logic [DW-1:0] l;
    for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = 32'(seed) * 32'h9E37_79B9 + 32'(i);
    return l;
  endfunction

  task automatic do_req(input logic is_wr, input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                        input logic v, input logic d, input logic [5:0] tag,
                        input logic [DW-1:0] line, input logic [DW-1:0] wline,
                        input logic exp_hit, input logic exp_wb);
    logic [AW-1:0] victim;
    bit got;
    victim = {tag, addr[25:6], 6'b0};
    if (!is_wr) begin
      if (exp_hit) rob_q.push_back({tid, line});
      else         ar_q.push_back({tid, addr});
    end else begin
      fill_q.push_back({addr, wline});
    end
    if (exp_wb) begin
      aw_q.push_back(victim);
      w_q.push_back(line);
    end
    if (exp_hit) m_hit = sat(m_hit);
    else         m_miss = sat(m_miss);
    if (exp_wb)  m_wb = sat(m_wb);
    @(posedge clk); #1;
    rvalid_i         = 1'b1;
    tag_fifo_empty_i = 1'b0;
    tag_fifo_data_i  = {is_wr, tid, addr};
    rdata_i          = {v, d, tag, 8'hA5, line};
    wbuffer_empty_i  = !is_wr;
    wbuffer_data_i   = wline;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rready_o) got = 1'b1;
    end
    if (!got) fail_now("accept_timeout");
    @(posedge clk); #1;
    rvalid_i         = 1'b0;
    tag_fifo_empty_i = 1'b1;
    wbuffer_empty_i  = 1'b1;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (rob_q.size() == 0 && ar_q.size() == 0 && aw_q.size() == 0 &&
          w_q.size() == 0 && fill_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      fail_now("drain_timeout");
      rob_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete(); fill_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag_name);
    check({tag_name, "_hit_cnt"}, hit_cnt_o, m_hit);
    check({tag_name, "_miss_cnt"}, miss_cnt_o, m_miss);
    check({tag_name, "_wb_cnt"}, wb_cnt_o, m_wb);
  endtask

  typedef struct {
    logic           is_write;
    logic [TW-1:0]  tid;
    logic [AW-1:0]  addr;
    logic           v;
    logic           d;
    logic [5:0]     tag;
    logic           exp_hit;
    logic           exp_wb;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   wb0, acc0;
    bit   seen;

    rst_n = 1'b0; rvalid_i = 1'b0; tag_fifo_empty_i = 1'b1; wbuffer_empty_i = 1'b1;
    rdata_i = '0; tag_fifo_data_i = '0; wbuffer_data_i = '0;
    rob_afull_i = 1'b0; ar_fifo_afull_i = 1'b0; aw_fifo_afull_i = 1'b0; w_fifo_afull_i = 1'b0;
    fill_ready_i = 1'b1; stat_clr_i = 1'b0;

    //                is_wr tid    addr           V     D     tag    hit   wb
    vecs[0] = '{1'b0, 4'd3,  32'h0400_0040, 1'b1, 1'b0, 6'h01, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'd5,  32'h0400_0040, 1'b1, 1'b1, 6'h15, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 4'd7,  32'h0800_1280, 1'b1, 1'b0, 6'h15, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'd9,  32'h0400_0040, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd2,  32'hFC00_00C0, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 4'd4,  32'h0C03_4560, 1'b1, 1'b1, 6'h0A, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 4'd6,  32'h1000_0000, 1'b0, 1'b1, 6'h04, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'd15, 32'hFFFF_FFC0, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rready", rready_o, 0);
    check("rst_tag_rden", tag_fifo_rden_o, 0);
    check("rst_wbuf_rden", wbuffer_rden_o, 0);
    check("rst_rob_wren", rob_wren_o, 0);
    check("rst_ar_wren", ar_fifo_wren_o, 0);
    check("rst_aw_wren", aw_fifo_wren_o, 0);
    check("rst_w_wren", w_fifo_wren_o, 0);
    check("rst_fill_valid", fill_valid_o, 0);
    check("rst_rob_data", rob_data_o, 0);
    check("rst_aw_data", aw_fifo_data_o, 0);
    check("rst_fill_data", fill_data_o, 0);
    check_counters("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wb0  = n_wbrd;
      acc0 = n_accept;
      do_req(vecs[i].is_write, vecs[i].tid, vecs[i].addr, vecs[i].v, vecs[i].d, vecs[i].tag,
             make_line(i + 1), make_line(i + 100), vecs[i].exp_hit, vecs[i].exp_wb);
      wait_drain();
      check($sformatf("vec%0d_accepts", i), n_accept - acc0, 1);
      check($sformatf("vec%0d_wbuf_rden", i), n_wbrd - wb0, vecs[i].is_write);
      check_counters($sformatf("vec%0d", i));
    end

    // Write hit with the fill arbiter stalled for five cycles
    fill_ready_i = 1'b0;
    n_fv = 0;
    wb0  = n_wbrd;
    do_req(1'b1, 4'd1, 32'h2000_0100, 1'b1, 1'b0, 6'h08, make_line(40), make_line(41), 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (fill_valid_o) seen = 1'b1;
    end
    if (!seen) fail_now("t4_fill_valid_timeout");
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    fill_ready_i = 1'b1;
    wait_drain();
    check("t4_fill_valid_cycles", n_fv, 6);
    check("t4_wbuf_rden", n_wbrd - wb0, 1);
    check_counters("t4");

    // Write miss with dirty victim while AW is almost full
    aw_fifo_afull_i = 1'b1;
    do_req(1'b1, 4'd8, 32'h3000_0200, 1'b1, 1'b1, 6'h21, make_line(50), make_line(51), 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    aw_fifo_afull_i = 1'b0;
    wait_drain();
    check("t5_fill_cycle", fill_cyc - acc_cyc, 2);
    check("t5_aw_cycle", aw_cyc - acc_cyc, 4);
    check_counters("t5");

    // Write entry without write-buffer data is never accepted
    acc0 = n_accept;
    @(posedge clk); #1;
    rvalid_i = 1'b1; tag_fifo_empty_i = 1'b0; wbuffer_empty_i = 1'b1;
    tag_fifo_data_i = {1'b1, 4'd2, 32'h0400_0040};
    repeat (5) begin
      @(negedge clk);
      check("t6_no_rready", rready_o, 0);
      check("t6_no_wbuf_rden", wbuffer_rden_o, 0);
    end
    @(posedge clk); #1;
    rvalid_i = 1'b0; tag_fifo_empty_i = 1'b1;
    check("t6_no_accept", n_accept - acc0, 0);

    // Clear coincides with the DEC-exit hit increment
    do_req(1'b0, 4'd3, 32'h0400_0040, 1'b1, 1'b0, 6'h01, make_line(60), '0, 1'b1, 1'b0);
    stat_clr_i = 1'b1;
    @(posedge clk); #1;
    stat_clr_i = 1'b0;
    m_hit = 0; m_miss = 0; m_wb = 0;
    wait_drain();
    check_counters("clr");

    // Saturation of the hit counter
    for (int i = 0; i < CMAX + 2; i++) begin
      do_req(1'b0, 4'(i), 32'h0400_0040, 1'b1, 1'b0, 6'h01, make_line(70 + i), '0, 1'b1, 1'b0);
      wait_drain();
    end
    check_counters("sat");
    check("sat_hit_value", hit_cnt_o, CMAX);

    // Reset while a fill is pending
    fill_ready_i = 1'b0;
    do_req(1'b1, 4'd5, 32'h2000_0100, 1'b1, 1'b0, 6'h08, make_line(90), make_line(91), 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (fill_valid_o) seen = 1'b1;
    end
    if (!seen) fail_now("rst_mid_fill_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_fill_valid", fill_valid_o, 0);
    check("rst_mid_fill_data", fill_data_o, 0);
    fill_q.delete();
    m_hit = 0; m_miss = 0; m_wb = 0;
    check_counters("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_ready_i = 1'b1;
    do_req(1'b0, 4'd6, 32'h0400_0040, 1'b1, 1'b0, 6'h01, make_line(95), '0, 1'b1, 1'b0);
    wait_drain();
    check_counters("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
